// File: rtl/time_display_scan.sv
// Snapshots a time or date page once per frame, converts it to BCD with a serial
// double-dabble engine and scans the result onto a 6-digit 7-segment display.
module time_display_scan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       page_sel,
    input  logic [7:0] second,
    input  logic [7:0] minute,
    input  logic [7:0] hour,
    input  logic [7:0] day,
    input  logic [7:0] month,
    input  logic [7:0] year,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       upd
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t state, state_next;

    logic [15:0] div_cnt;
    logic [2:0]  digit_idx;
    logic [2:0]  idx_next;
    logic        pending;
    logic        div_term;
    logic        snap;

    logic [8:0]  val_a;
    logic [8:0]  val_b;
    logic [8:0]  val_c;

    logic [7:0]  work_bin;
    logic [7:0]  work_bcd;
    logic [7:0]  bcd_adj;
    logic [7:0]  bcd_shift;
    logic [7:0]  bin_b;
    logic [7:0]  bin_c;
    logic [2:0]  bit_cnt;
    logic [1:0]  field_idx;
    logic        last_bit;
    logic [7:0]  res_a;
    logic [7:0]  res_b;
    logic [7:0]  res_c;
    logic [2:0]  dash_snap;

    logic [23:0] disp_bcd;
    logic [2:0]  disp_dash;

    logic [3:0]  cur_nib;
    logic        cur_dash;
    logic [6:0]  seg_next;
    logic [5:0]  an_next;

    assign div_term = (div_cnt == 16'(SCAN_DIV - 1));
    // The pending flag forces one snapshot on the first edge out of reset.
    assign snap     = pending | (div_term & (digit_idx == 3'd0));

    always_comb begin
        idx_next = digit_idx;
        if (div_term) begin
            if (digit_idx == 3'd0) begin
                idx_next = 3'd5;
            end else begin
                idx_next = digit_idx - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            digit_idx <= 3'd5;
            pending   <= 1'b1;
        end else begin
            pending   <= 1'b0;
            div_cnt   <= div_term ? 16'd0 : div_cnt + 16'd1;
            digit_idx <= idx_next;
        end
    end

    // Day and month are 0-based, so the date page shows them +1 at 9-bit width.
    always_comb begin
        if (page_sel) begin
            val_a = {1'b0, day} + 9'd1;
            val_b = {1'b0, month} + 9'd1;
            val_c = {1'b0, year};
        end else begin
            val_a = {1'b0, hour};
            val_b = {1'b0, minute};
            val_c = {1'b0, second};
        end
    end

    always_comb begin
        bcd_adj = work_bcd;
        if (work_bcd[3:0] >= 4'd5) begin
            bcd_adj[3:0] = work_bcd[3:0] + 4'd3;
        end
        if (work_bcd[7:4] >= 4'd5) begin
            bcd_adj[7:4] = work_bcd[7:4] + 4'd3;
        end
    end

    assign bcd_shift = {bcd_adj[6:0], work_bin[7]};
    assign last_bit  = (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (snap) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit && (field_idx == 2'd2)) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fields are converted one after another through a single shared nibble adjuster.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_bin  <= '0;
            work_bcd  <= '0;
            bin_b     <= '0;
            bin_c     <= '0;
            bit_cnt   <= '0;
            field_idx <= '0;
            res_a     <= '0;
            res_b     <= '0;
            res_c     <= '0;
            dash_snap <= '0;
            disp_bcd  <= '0;
            disp_dash <= '0;
            upd       <= 1'b0;
        end else begin
            upd <= (state == COMMIT);
            if ((state == IDLE) && snap) begin
                work_bin  <= val_a[7:0];
                bin_b     <= val_b[7:0];
                bin_c     <= val_c[7:0];
                work_bcd  <= '0;
                bit_cnt   <= '0;
                field_idx <= '0;
                dash_snap <= {val_a > 9'd99, val_b > 9'd99, val_c > 9'd99};
            end else if (state == SHIFT) begin
                bit_cnt  <= bit_cnt + 3'd1;
                work_bin <= {work_bin[6:0], 1'b0};
                work_bcd <= bcd_shift;
                if (last_bit) begin
                    work_bcd  <= '0;
                    field_idx <= field_idx + 2'd1;
                    case (field_idx)
                        2'd0: begin
                            res_a    <= bcd_shift;
                            work_bin <= bin_b;
                        end
                        2'd1: begin
                            res_b    <= bcd_shift;
                            work_bin <= bin_c;
                        end
                        default: begin
                            res_c <= bcd_shift;
                        end
                    endcase
                end
            end else if (state == COMMIT) begin
                disp_bcd  <= {res_a, res_b, res_c};
                disp_dash <= dash_snap;
            end
        end
    end

    always_comb begin
        cur_nib  = disp_bcd[3:0];
        cur_dash = disp_dash[0];
        case (idx_next)
            3'd5: begin
                cur_nib  = disp_bcd[23:20];
                cur_dash = disp_dash[2];
            end
            3'd4: begin
                cur_nib  = disp_bcd[19:16];
                cur_dash = disp_dash[2];
            end
            3'd3: begin
                cur_nib  = disp_bcd[15:12];
                cur_dash = disp_dash[1];
            end
            3'd2: begin
                cur_nib  = disp_bcd[11:8];
                cur_dash = disp_dash[1];
            end
            3'd1: begin
                cur_nib  = disp_bcd[7:4];
                cur_dash = disp_dash[0];
            end
            default: begin
                cur_nib  = disp_bcd[3:0];
                cur_dash = disp_dash[0];
            end
        endcase
    end

    always_comb begin
        seg_next = 7'b0111111;
        if (!cur_dash) begin
            case (cur_nib)
                4'd0:    seg_next = 7'b1000000;
                4'd1:    seg_next = 7'b1111001;
                4'd2:    seg_next = 7'b0100100;
                4'd3:    seg_next = 7'b0110000;
                4'd4:    seg_next = 7'b0011001;
                4'd5:    seg_next = 7'b0010010;
                4'd6:    seg_next = 7'b0000010;
                4'd7:    seg_next = 7'b1111000;
                4'd8:    seg_next = 7'b0000000;
                4'd9:    seg_next = 7'b0010000;
                default: seg_next = 7'b0111111;
            endcase
        end
    end

    assign an_next = ~(6'b000001 << idx_next);

    // Outputs follow the next digit index so an, seg and dp switch on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 6'b111111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= !((idx_next == 3'd4) || (idx_next == 3'd2));
        end
    end

endmodule

// File: doc/time_display_scan.md
# time_display_scan

Downstream consumer of the calendar timer's six 8-bit binary fields (`second`, `minute`, `hour`, `day`, `month`, `year`). The block snapshots one page of three fields per refresh frame, either time or date. It converts them to BCD with a sequential shift-add-3 engine and drives a 6-digit multiplexed 7-segment display (active-low segments and anodes). Snapshotting once per frame prevents torn readouts while the timer counters ripple.

## Interface
- `SCAN_DIV`, default 1000: clk cycles each digit stays lit. Legal range 8..65535.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `page_sel`  in  1  0 = time page (hh mm ss), 1 = date page (dd mm yy).
- `second`, `minute`, `hour`, `day`, `month`, `year`  in  8 each  binary field values from the timer. `day` and `month` are 0-based.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  6  digit enables, one-hot active-low. Bit 5 is the leftmost digit.
- `upd`  out  1  one-cycle pulse when new BCD values are committed to the display registers.

## Operation
- **Page content, digits 5..0:**
  - Time page: H1 H0 M1 M0 S1 S0.
  - Date page: D1 D0 N1 N0 Y1 Y0, where D = `day`+1, N = `month`+1, Y = `year` unchanged.
  - Field A is digits 5:4, field B is digits 3:2, field C is digits 1:0.
- **Range rule:** a field value > 99, after the +1 adjustment where it applies, displays as two dashes. The adjustment is computed at 9-bit width, so `day` = 255 becomes 256 and displays as dashes.
- **Leading zeros** are shown. Example: 7 displays as "07".
- **Separators:** `dp` is low while digit 4 or digit 2 is enabled, high otherwise.
- **Scan:**
  - A divider counts 0..`SCAN_DIV`-1.
  - On the terminal count the digit index advances 5→4→…→0→5.
  - `an` bit[index] = 0, all other bits = 1. `seg`/`dp` show that digit.
- **Snapshot event S** fires on either condition:
  - the frame end, i.e. divider at terminal count and index = 0;
  - the first clk edge after `reset` deasserts, via a pending flag set by reset.
  - At S, the three fields and the page (adjusted) are latched into the conversion engine.
- **Conversion FSM:**
  - IDLE: wait for S.
  - SHIFT: 8 double-dabble iterations per field (add 3 to any BCD nibble ≥ 5, then shift left 1), fields A, B, C in order, 24 cycles total.
  - COMMIT: write all six BCD digits (or the dash flags) to the display registers in a single edge, pulse `upd`, return to IDLE.
- **Input changes:** changes to any input field or to `page_sel` outside the snapshot edge have no effect until the next S.
- **Scan independence:** the scan runs continuously and independently of the FSM. Display registers change only at COMMIT.
- **Segment codes, {g..a} active-low:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111

## Timing
- **Reset values (reset low):**
  - `an`=111111, `seg`=1111111, `dp`=1, `upd`=0.
  - Divider=0, digit index=5, display registers all zero with dash flags clear, FSM=IDLE, pending flag=1.
  - Reset mid-conversion aborts the conversion with no commit.
- **First display after release:**
  - `an`/`seg`/`dp` are registered.
  - After the first edge, `an`=011111 and `seg` shows "0" until the first commit.
- **Conversion latency:** snapshot at edge S; SHIFT occupies edges S+1..S+24; COMMIT at edge S+25.
  - `upd` is high for exactly the cycle after edge S+25.
  - New digit values appear on `seg` from edge S+26 onward, whenever their digit is scanned.
- **Digit timing:** each digit is lit for exactly `SCAN_DIV` cycles; a frame is 6×`SCAN_DIV` cycles.
  - `an`, `seg` and `dp` change on the same edge; there is no blanking interval.
- **Overlapping snapshot:** because `SCAN_DIV` ≥ 8, a conversion always finishes before the next S. An S arriving while the FSM is not IDLE cannot occur; no queueing is required.

## Test plan
1. **Reset:** drive `reset`=0 mid-scan → `an`=111111, `seg`=1111111, `dp`=1, `upd`=0 immediately, without waiting for a clock edge.
2. **Time page** (`SCAN_DIV`=8, `hour`=23, `minute`=59, `second`=7, `page_sel`=0): `upd` pulses 26 cycles after the post-reset S.
   - Next frame, digits 5..0 show 0100100, 0110000, 0010010, 0010000, 1000000, 1111000.
   - `dp`=0 only on digits 4 and 2.
3. **Date page** (`day`=29, `month`=11, `year`=10, `page_sel`=1) → digits 5..0 display 3 0 1 2 1 0.
4. **Range:** `second`=100 → digits 1:0 show 0111111. `day`=255 on the date page → digits 5:4 show dashes.
5. **Coherence:** change `minute` from 59 to 0 and toggle `page_sel` 3 cycles after S → display keeps the old values until COMMIT of the following S. Check `upd` spacing = 6×`SCAN_DIV` cycles.
6. **Reset mid-SHIFT:** assert reset at S+10, release → no `upd` from the aborted conversion.
   - The next `upd` arrives 26 cycles after the first post-release edge; the display shows zeros until then.
